// File: rtl/sq_out_normalizer.sv
// ============================================================================
// Module   : sq_out_normalizer
// Brief    : Serial carry propagation of a redundant coefficient vector into a
//            canonical MOD_LEN-bit result, with overflow and overrun flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sq_out_normalizer #(
    parameter int MOD_LEN      = 1024,
    parameter int WORD_LEN     = 50,
    parameter int BIT_LEN      = 51,
    parameter int NUM_ELEMENTS = 21
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_ELEMENTS*BIT_LEN-1:0] sq_coeffs,
    output logic [MOD_LEN-1:0]              result,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            overflow,
    output logic                            overrun,
    output logic                            busy
);

    localparam int c_TOP_BITS = MOD_LEN - (NUM_ELEMENTS - 1) * WORD_LEN;
    localparam int c_VEC_W    = NUM_ELEMENTS * BIT_LEN;
    localparam int c_IDX_W    = $clog2(NUM_ELEMENTS + 1);
    localparam int c_CARRY_W  = BIT_LEN - WORD_LEN + 1;
    localparam int c_SUM_W    = BIT_LEN + 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_ELEMENTS - 1);

    if ((c_TOP_BITS < 1) || (c_TOP_BITS > WORD_LEN)) begin : g_bad_top_bits
        $error("sq_out_normalizer: TOP_BITS=%0d outside 1..WORD_LEN", c_TOP_BITS);
    end

    if (BIT_LEN <= WORD_LEN) begin : g_bad_bit_len
        $error("sq_out_normalizer: BIT_LEN must exceed WORD_LEN");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [c_IDX_W-1:0]     r_index;
    logic [c_CARRY_W-1:0]   r_carry;
    logic [c_VEC_W-1:0]     r_shift;
    logic [MOD_LEN-1:0]     r_result;
    logic                   r_overflow;
    logic                   r_overrun;
    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_last;
    logic [c_SUM_W-1:0]     w_sum;

    assign w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_last     = (r_index == c_LAST_IDX);

    // Current coefficient always sits at the bottom of the shift register.
    assign w_sum = {1'b0, r_shift[BIT_LEN-1:0]}
                 + {{(c_SUM_W - c_CARRY_W){1'b0}}, r_carry};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_accept) begin
                    w_next_state = ST_RUN;
                end else if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_index    <= '0;
            r_carry    <= '0;
            r_shift    <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (in_valid && !w_in_ready) begin
                r_overrun <= 1'b1;
            end

            if (w_accept) begin
                r_shift    <= sq_coeffs;
                r_carry    <= '0;
                r_index    <= '0;
                r_overflow <= 1'b0;
            end else if (r_state == ST_RUN) begin
                r_shift <= r_shift >> BIT_LEN;
                r_carry <= w_sum[BIT_LEN:WORD_LEN];
                r_index <= r_index + c_IDX_W'(1);

                for (int k = 0; k < NUM_ELEMENTS - 1; k++) begin
                    if (r_index == c_IDX_W'(k)) begin
                        r_result[k*WORD_LEN +: WORD_LEN] <= w_sum[WORD_LEN-1:0];
                    end
                end

                // Last coefficient only contributes TOP_BITS; anything above is overflow.
                if (w_last) begin
                    r_result[MOD_LEN-1 -: c_TOP_BITS] <= w_sum[c_TOP_BITS-1:0];
                    if (|w_sum[BIT_LEN:c_TOP_BITS]) begin
                        r_overflow <= 1'b1;
                    end
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign result    = r_result;
    assign out_valid = (r_state == ST_DONE);
    assign overflow  = r_overflow;
    assign overrun   = r_overrun;
    assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sq_out_normalizer.sv
// ============================================================================
// Module   : tb_sq_out_normalizer
// Brief    : Scoreboard bench for sq_out_normalizer (full-precision model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sq_out_normalizer;

    localparam int MOD_LEN      = 1024;
    localparam int WORD_LEN     = 50;
    localparam int BIT_LEN      = 51;
    localparam int NUM_ELEMENTS = 21;
    localparam int VEC_W        = NUM_ELEMENTS * BIT_LEN;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [VEC_W-1:0]   sq_coeffs;
    logic [MOD_LEN-1:0] result;
    logic               out_valid;
    logic               out_ready;
    logic               overflow;
    logic               overrun;
    logic               busy;

    sq_out_normalizer #(
        .MOD_LEN      (MOD_LEN),
        .WORD_LEN     (WORD_LEN),
        .BIT_LEN      (BIT_LEN),
        .NUM_ELEMENTS (NUM_ELEMENTS)
    ) u_dut (
        .clk       (clk),
        .reset     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sq_coeffs (sq_coeffs),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .overrun   (overrun),
        .busy      (busy)
    );

    typedef struct {
        logic [MOD_LEN-1:0] res;
        logic               ovf;
        int                 acc;
    } exp_t;

    exp_t               sb[$];
    int                 n_total = 0;
    int                 n_bad   = 0;
    int                 cyc     = 0;
    int                 n_out   = 0;
    int                 n_rise  = 0;
    int                 want    = 0;
    logic [MOD_LEN-1:0] last_res = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Full-precision weighted sum, independent of the serial carry scheme.
    function automatic exp_t model(input logic [VEC_W-1:0] v, input int acc);
        exp_t          m;
        logic [1099:0] s;
        s = '0;
        for (int j = 0; j < NUM_ELEMENTS; j++) begin
            s = s + (1100'(v[j*BIT_LEN +: BIT_LEN]) << (WORD_LEN * j));
        end
        m.res = s[MOD_LEN-1:0];
        m.ovf = |s[1099:MOD_LEN];
        m.acc = acc;
        return m;
    endfunction

    task automatic send(input logic [VEC_W-1:0] v, input logic rdy, output logic acc);
        @(negedge clk);
        sq_coeffs = v;
        in_valid  = 1'b1;
        out_ready = rdy;
        #1;
        acc = in_ready;
        if (acc) begin
            sb.push_back(model(v, cyc + 1));
            want++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_outs();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #3;
            if (n_out >= want) break;
        end
        check_eq("out_timeout", 256'(n_out >= want), 256'd1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #3;
            if (out_valid) break;
        end
        check_eq("valid_timeout", 256'(out_valid), 256'd1);
    endtask

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [VEC_W-1:0] v;
        for (int j = 0; j < NUM_ELEMENTS; j++) begin
            v[j*BIT_LEN +: BIT_LEN] = 51'({$urandom(), $urandom()});
        end
        return v;
    endfunction

    initial begin : monitor
        exp_t e;
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_valid", 256'd1, 256'd0);
                end else begin
                    e = sb[0];
                    if (!prev_v) begin
                        n_rise++;
                        check_eq("latency", 256'(cyc), 256'(e.acc + 21));
                    end
                    for (int c = 0; c < 4; c++) begin
                        check_eq($sformatf("res%0d", c), result[c*256 +: 256], e.res[c*256 +: 256]);
                    end
                    check_eq("ovf", 256'(overflow), 256'(e.ovf));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        last_res = e.res;
                        n_out++;
                    end
                end
            end
            prev_v = out_valid;
        end
    end

    initial begin : driver
        logic [VEC_W-1:0] v;
        logic             acc;
        int               r0;
        int               o0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sq_coeffs = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid",  256'(out_valid), 256'd0);
        check_eq("rst_busy",   256'(busy),      256'd0);
        check_eq("rst_ready",  256'(in_ready),  256'd1);
        check_eq("rst_ovr",    256'(overrun),   256'd0);
        check_eq("rst_ovf",    256'(overflow),  256'd0);
        check_eq("rst_res_lo", result[255:0],   256'd0);
        check_eq("rst_res_hi", result[1023:768], 256'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // All-zero vector
        send('0, 1'b1, acc);
        wait_outs();
        check_eq("zero_ovr", 256'(overrun), 256'd0);

        // Single 2^50 in coefficient 0
        v = '0;
        v[0 +: BIT_LEN] = 51'h4_0000_0000_0000;
        send(v, 1'b1, acc);
        wait_outs();

        // Carry ripples through every word to bit 1000
        v = '0;
        v[0 +: BIT_LEN] = 51'h4_0000_0000_0000;
        for (int j = 1; j < 20; j++) v[j*BIT_LEN +: BIT_LEN] = 51'h3_FFFF_FFFF_FFFF;
        send(v, 1'b1, acc);
        wait_outs();
        check_eq("ripple_bit", 256'(result[1000]), 256'd1);

        // Top coefficient just over / just within the 24 top bits
        v = '0;
        v[20*BIT_LEN +: BIT_LEN] = 51'h100_0000;
        send(v, 1'b1, acc);
        wait_outs();
        v[20*BIT_LEN +: BIT_LEN] = 51'h0FF_FFFF;
        send(v, 1'b1, acc);
        wait_outs();

        // Input arriving mid-RUN is dropped and flagged
        r0 = n_rise;
        send(rand_vec(), 1'b1, acc);
        repeat (4) @(posedge clk);
        send(rand_vec(), 1'b1, acc);
        check_eq("ovr_accept", 256'(acc), 256'd0);
        wait_outs();
        repeat (30) @(negedge clk);
        check_eq("ovr_flag",  256'(overrun), 256'd1);
        check_eq("ovr_nrise", 256'(n_rise - r0), 256'd1);

        // New vector accepted in the same cycle DONE is acknowledged
        send(rand_vec(), 1'b0, acc);
        wait_valid();
        send(rand_vec(), 1'b1, acc);
        check_eq("coinc_accept", 256'(acc), 256'd1);
        wait_outs();

        // Backpressure: result must hold for 50 cycles
        send(rand_vec(), 1'b0, acc);
        wait_valid();
        repeat (50) @(negedge clk);
        o0 = n_out;
        out_ready = 1'b1;
        @(negedge clk);
        #3;
        check_eq("bp_handshake", 256'(n_out - o0), 256'd1);
        check_eq("bp_idle",      256'(out_valid),  256'd0);
        check_eq("bp_hold",      result[1023:768], last_res[1023:768]);

        // Asynchronous reset at RUN index 10
        send(rand_vec(), 1'b1, acc);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 256'(out_valid), 256'd0);
        check_eq("mid_rst_busy",  256'(busy),      256'd0);
        check_eq("mid_rst_ready", 256'(in_ready),  256'd1);
        check_eq("mid_rst_ovr",   256'(overrun),   256'd0);
        sb.delete();
        want = n_out;
        @(negedge clk);
        rst_n = 1'b1;
        send(rand_vec(), 1'b1, acc);
        wait_outs();

        for (int k = 0; k < 3; k++) begin
            send(rand_vec(), 1'b1, acc);
            wait_outs();
        end
        check_eq("final_hold", result[255:0], last_res[255:0]);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sq_out_normalizer.md
Name: sq_out_normalizer

Overview:
- Downstream of the modular squaring wrapper, in the clk domain.
- Consumes the redundant 21 x 51-bit coefficient vector delivered with the single-cycle valid pulse.
- Serially propagates carries, one coefficient per cycle, to rebuild a canonical MOD_LEN-bit result for the host/output path.
- Flags values that exceed MOD_LEN bits, and flags inputs that arrive while the block is busy.

Parameters:
- MOD_LEN, 1024, width of the canonical result.
- WORD_LEN, 50, canonical bits per coefficient.
- BIT_LEN, 51, stored bits per redundant input coefficient.
- NUM_ELEMENTS, 21, coefficient count.
- TOP_BITS, MOD_LEN-(NUM_ELEMENTS-1)*WORD_LEN (=24), result bits taken from the last coefficient. Must satisfy 1..WORD_LEN; elaboration error otherwise.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  coefficient vector present; single-cycle pulse from the valid CDC.
- in_ready  out  1  block can accept in this cycle.
- sq_coeffs  in  NUM_ELEMENTS*BIT_LEN  coefficient j at [j*BIT_LEN +: BIT_LEN].
- result  out  MOD_LEN  canonical value, stable while out_valid.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- overflow  out  1  value >= 2^MOD_LEN; valid with out_valid.
- overrun  out  1  sticky; an input was dropped.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, async): state IDLE, index=0, carry=0, result=0, out_valid=0, overflow=0, overrun=0, busy=0, in_ready=1.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept: an edge with in_valid & in_ready. Captures sq_coeffs into a shift register, clears carry, index and overflow, and moves to RUN.
- RUN, one edge per coefficient j = index:
  - sum[BIT_LEN:0] = coeff[j] + carry.
  - j < NUM_ELEMENTS-1: write result[j*WORD_LEN +: WORD_LEN] = sum[WORD_LEN-1:0]; carry = sum >> WORD_LEN.
  - carry never exceeds 2 (sum < 3*2^50), so the carry register is 2 bits.
  - j = NUM_ELEMENTS-1: write result[MOD_LEN-1 -: TOP_BITS] = sum[TOP_BITS-1:0]. If sum >> TOP_BITS is nonzero, set overflow=1.
  - The last RUN edge moves the state to DONE.
- Latency: out_valid is high starting exactly NUM_ELEMENTS edges after the accepting edge (21 cycles).
- DONE: out_valid=1, with result and overflow held stable.
  - out_ready=1 with no new input: return to IDLE and drop out_valid next edge. result keeps its last value.
  - out_ready=1 and in_valid in the same cycle: the new vector is accepted and the state goes directly to RUN. out_valid drops.
- Overrun: in_valid=1 while in_ready=0 (RUN, or DONE without out_ready) drops the input and sets overrun=1. overrun clears only on reset. The in-flight computation is unaffected.
- Results are only ever written in RUN; result never changes while out_valid=1.
- Reset asserted mid-RUN or in DONE: immediate return to reset values. A partial result is never presented.
- Inputs are treated as unsigned. No modular reduction is performed here; overflow only reports the condition.

Test Plan:
- All coefficients 0, in_valid pulse -> out_valid after 21 cycles; result=0, overflow=0, overrun=0.
- coeff0=2^50, rest 0 -> result=2^50 (bit 50 set only), overflow=0.
- coeff0=2^50, coeff1..19=2^50-1, coeff20=0 -> carry ripples through all words; result=2^1000, overflow=0.
- coeff20=2^24, rest 0 -> result=0, overflow=1. Separately, coeff20=2^24-1, rest 0 -> result bits 1023:1000 all 1, overflow=0.
- Overlapping inputs:
  - Second in_valid 5 cycles after the first accept -> overrun=1; the first result is correct; exactly one out_valid occurs.
  - in_valid coincident with out_ready in DONE -> accepted; a second result appears 21 cycles later.
- Reset mid-operation:
  - Reset asserted at RUN index 10 -> out_valid=0, busy=0, in_ready=1 immediately.
  - After release, a fresh vector yields a correct result with no stale words from the aborted run.
- Backpressure: out_ready held 0 for 50 cycles -> out_valid and result stay stable throughout; the result is accepted on the first cycle out_ready=1.
